// File: rtl/uart_alu_pkg.sv
// ============================================================================
// Module      : uart_alu_pkg
// Description : Shared opcodes, register locations, command byte and FSM
//               state encodings for the UART-controlled ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_alu_pkg;

   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b100010;
   localparam logic [5:0] OP_AND = 6'b100100;
   localparam logic [5:0] OP_OR  = 6'b100101;
   localparam logic [5:0] OP_XOR = 6'b100110;
   localparam logic [5:0] OP_NOR = 6'b100111;
   localparam logic [5:0] OP_SRA = 6'b000011;
   localparam logic [5:0] OP_SRL = 6'b000010;

   localparam logic [7:0] LOC_A   = 8'h00;
   localparam logic [7:0] LOC_B   = 8'h01;
   localparam logic [7:0] LOC_OP  = 8'h02;
   localparam logic [7:0] CMD_GET = 8'hFF;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   typedef enum logic [0:0] {
      IF_WAIT_CMD = 1'b0,
      IF_WAIT_VAL = 1'b1
   } if_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_alu_core.sv
// ============================================================================
// Module      : uart_alu_core
// Description : Two-byte command interface, A/B/OP registers and the
//               combinational ALU feeding the transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_alu_core
   import uart_alu_pkg::*;
#(
   parameter int NB_DATA = 8,
   parameter int NB_OPS  = 6
)
(
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_rx_done,
   input  logic [NB_DATA-1:0] i_rx_byte,
   input  logic               i_tx_busy,
   output logic               o_tx_start,
   output logic [NB_DATA-1:0] o_result
);

   if_state_t          r_state;
   if_state_t          w_state_next;
   logic [NB_DATA-1:0] r_a;
   logic [NB_DATA-1:0] r_b;
   logic [NB_OPS-1:0]  r_op;
   logic [NB_DATA-1:0] r_loc;
   logic [NB_DATA-1:0] w_result;

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= IF_WAIT_CMD;
      else         r_state <= w_state_next;
   end

   // A get command never leaves WAIT_CMD; only a location byte arms WAIT_VAL.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IF_WAIT_CMD: if (i_rx_done && (i_rx_byte != CMD_GET)) w_state_next = IF_WAIT_VAL;
         IF_WAIT_VAL: if (i_rx_done) w_state_next = IF_WAIT_CMD;
         default:     w_state_next = IF_WAIT_CMD;
      endcase
   end

   always_comb begin
      o_tx_start = (r_state == IF_WAIT_CMD) && i_rx_done &&
                   (i_rx_byte == CMD_GET) && !i_tx_busy;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_a   <= '0;
         r_b   <= '0;
         r_op  <= OP_ADD;
         r_loc <= '0;
      end else if (i_rx_done) begin
         if (r_state == IF_WAIT_CMD) begin
            r_loc <= i_rx_byte;
         end else begin
            case (r_loc)
               LOC_A:   r_a  <= i_rx_byte;
               LOC_B:   r_b  <= i_rx_byte;
               LOC_OP:  r_op <= i_rx_byte[NB_OPS-1:0];
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      w_result = '0;
      case (r_op)
         OP_ADD:  w_result = r_a + r_b;
         OP_SUB:  w_result = r_a - r_b;
         OP_AND:  w_result = r_a & r_b;
         OP_OR:   w_result = r_a | r_b;
         OP_XOR:  w_result = r_a ^ r_b;
         OP_NOR:  w_result = ~(r_a | r_b);
         OP_SRA:  w_result = $unsigned($signed(r_a) >>> r_b);
         OP_SRL:  w_result = r_a >> r_b;
         default: w_result = '0;
      endcase
   end

   assign o_result = w_result;

endmodule

`default_nettype wire

// File: rtl/uart_alu_top.sv
// ============================================================================
// Module      : uart_alu_top
// Description : UART-controlled ALU: 16x-oversampling 8N1 receiver, command
//               core and 8N1 transmitter sharing one tick generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_alu_top
   import uart_alu_pkg::*;
#(
   parameter int NB_DATA       = 8,
   parameter int NB_OPS        = 6,
   parameter int CLKS_PER_TICK = 611
)
(
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_rx_data,
   output logic o_tx_serial_data
);

   localparam int                  NB_TICK   = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
   localparam logic [NB_TICK-1:0]  TICK_LAST = NB_TICK'(CLKS_PER_TICK - 1);
   localparam int                  NB_BITS   = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
   localparam logic [NB_BITS-1:0]  BIT_LAST  = NB_BITS'(NB_DATA - 1);

   logic [NB_TICK-1:0] r_tick_cnt;
   logic               w_tick;
   logic               r_rx_meta;
   logic               r_rx_sync;

   rx_state_t          r_rx_state;
   rx_state_t          w_rx_next;
   logic [3:0]         r_rx_ticks;
   logic [NB_BITS-1:0] r_rx_bits;
   logic [NB_DATA-1:0] r_rx_shift;
   logic               w_rx_done;

   tx_state_t          r_tx_state;
   tx_state_t          w_tx_next;
   logic [3:0]         r_tx_ticks;
   logic [NB_BITS-1:0] r_tx_bits;
   logic [NB_DATA-1:0] r_tx_shift;
   logic               r_tx_line;
   logic               w_tx_bit;
   logic               w_tx_busy;
   logic               w_tx_start;
   logic [NB_DATA-1:0] w_result;

   assign w_tick = (r_tick_cnt == TICK_LAST);

   always_ff @(posedge i_clk) begin
      if (i_reset || w_tick) r_tick_cnt <= '0;
      else                   r_tick_cnt <= r_tick_cnt + 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
      end else begin
         r_rx_meta <= i_rx_data;
         r_rx_sync <= r_rx_meta;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) r_rx_state <= RX_IDLE;
      else         r_rx_state <= w_rx_next;
   end

   always_comb begin
      w_rx_next = r_rx_state;
      case (r_rx_state)
         RX_IDLE:  if (!r_rx_sync) w_rx_next = RX_START;
         RX_START: if (w_tick && (r_rx_ticks == 4'd7)) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (w_tick && (r_rx_ticks == 4'd15) && (r_rx_bits == BIT_LAST)) w_rx_next = RX_STOP;
         RX_STOP:  if (w_tick && (r_rx_ticks == 4'd15)) w_rx_next = RX_IDLE;
         default:  w_rx_next = RX_IDLE;
      endcase
   end

   always_comb begin
      w_rx_done = (r_rx_state == RX_STOP) && w_tick && (r_rx_ticks == 4'd15);
   end

   // The 4-bit tick counter wraps 15->0, so only state changes need to clear it.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rx_ticks <= '0;
         r_rx_bits  <= '0;
         r_rx_shift <= '0;
      end else begin
         if (r_rx_state != w_rx_next) r_rx_ticks <= '0;
         else if (w_tick)             r_rx_ticks <= r_rx_ticks + 1'b1;
         if (r_rx_state == RX_START) begin
            r_rx_bits <= '0;
         end else if ((r_rx_state == RX_DATA) && w_tick && (r_rx_ticks == 4'd15)) begin
            r_rx_shift <= {r_rx_sync, r_rx_shift[NB_DATA-1:1]};
            r_rx_bits  <= r_rx_bits + 1'b1;
         end
      end
   end

   uart_alu_core #(
      .NB_DATA (NB_DATA),
      .NB_OPS  (NB_OPS)
   ) u_core (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_rx_done  (w_rx_done),
      .i_rx_byte  (r_rx_shift),
      .i_tx_busy  (w_tx_busy),
      .o_tx_start (w_tx_start),
      .o_result   (w_result)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) r_tx_state <= TX_IDLE;
      else         r_tx_state <= w_tx_next;
   end

   always_comb begin
      w_tx_next = r_tx_state;
      case (r_tx_state)
         TX_IDLE:  if (w_tx_start) w_tx_next = TX_START;
         TX_START: if (w_tick && (r_tx_ticks == 4'd15)) w_tx_next = TX_DATA;
         TX_DATA:  if (w_tick && (r_tx_ticks == 4'd15) && (r_tx_bits == BIT_LAST)) w_tx_next = TX_STOP;
         TX_STOP:  if (w_tick && (r_tx_ticks == 4'd15)) w_tx_next = TX_IDLE;
         default:  w_tx_next = TX_IDLE;
      endcase
   end

   always_comb begin
      w_tx_busy = (r_tx_state != TX_IDLE);
      case (r_tx_state)
         TX_START: w_tx_bit = 1'b0;
         TX_DATA:  w_tx_bit = r_tx_shift[0];
         default:  w_tx_bit = 1'b1;
      endcase
   end

   // The result is snapshotted at tx_start so later register writes cannot disturb the frame.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_tx_ticks <= '0;
         r_tx_bits  <= '0;
         r_tx_shift <= '0;
         r_tx_line  <= 1'b1;
      end else begin
         r_tx_line <= w_tx_bit;
         if (r_tx_state != w_tx_next) r_tx_ticks <= '0;
         else if (w_tick)             r_tx_ticks <= r_tx_ticks + 1'b1;
         if ((r_tx_state == TX_IDLE) && w_tx_start) begin
            r_tx_shift <= w_result;
            r_tx_bits  <= '0;
         end else if ((r_tx_state == TX_DATA) && w_tick && (r_tx_ticks == 4'd15)) begin
            r_tx_shift <= {1'b0, r_tx_shift[NB_DATA-1:1]};
            r_tx_bits  <= r_tx_bits + 1'b1;
         end
      end
   end

   assign o_tx_serial_data = r_tx_line;

endmodule

`default_nettype wire

// File: tb/tb_uart_alu_top.sv
// ============================================================================
// Module      : tb_uart_alu_top
// Description : Directed self-checking bench; drives 8N1 frames into the ALU
//               and decodes the transmitted result frames.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_alu_top;

   localparam int CLKS_PER_TICK = 2;
   localparam int BIT     = 16 * CLKS_PER_TICK;
   localparam int GAP     = BIT;
   localparam int LAT_MIN = 152 * CLKS_PER_TICK - 8;
   localparam int LAT_MAX = 152 * CLKS_PER_TICK + 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx  = 1'b1;
   logic tx;
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   t_rx_start = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_alu_top #(
      .NB_DATA       (8),
      .NB_OPS        (6),
      .CLKS_PER_TICK (CLKS_PER_TICK)
   ) dut (
      .i_clk            (clk),
      .i_reset          (rst),
      .i_rx_data        (rx),
      .o_tx_serial_data (tx)
   );

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(negedge clk);
      t_rx_start = cyc;
      rx = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT) @(negedge clk);
      end
      rx = 1'b1;
      repeat (BIT + gap) @(negedge clk);
   endtask

   task automatic write_reg(input logic [7:0] loc, input logic [7:0] val);
      send_byte(loc, GAP);
      send_byte(val, GAP);
   endtask

   // fr[0] is the start bit, fr[9] the stop bit; all X if no frame appears.
   task automatic capture(output logic [9:0] fr, output int lat);
      int w;
      fr  = 'x;
      lat = -1;
      w   = 0;
      while (tx === 1'b1 && w < 20 * BIT) begin
         @(negedge clk);
         w++;
      end
      if (tx === 1'b0) begin
         lat = cyc - t_rx_start;
         for (int i = 0; i < 10; i++) begin
            repeat ((i == 0) ? BIT / 2 : BIT) @(negedge clk);
            fr[i] = tx;
         end
      end
   endtask

   task automatic read_result(output logic [9:0] fr, output int lat);
      logic [9:0] f;
      int         l;
      fork
         send_byte(8'hFF, GAP);
         capture(f, l);
      join
      fr  = f;
      lat = l;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (5) @(negedge clk);
      n_chk++;
      if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_line: got %b want 1", tx); end
      rst = 1'b0;
      @(negedge clk);
      n_chk++;
      if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_release_line: got %b want 1", tx); end
   endtask

   task automatic test_idle();
      int lows = 0;
      repeat (2000) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      n_chk++;
      if (lows !== 0) begin n_fail++; $display("FAIL idle_line: %0d low cycles, want 0", lows); end
   endtask

   task automatic test_add();
      logic [9:0] fr;
      int         lat;
      write_reg(8'h00, 8'h4F);
      read_result(fr, lat);
      n_chk++;
      if (fr !== 10'b1010011110) begin n_fail++; $display("FAIL add_frame: got %b want %b", fr, 10'b1010011110); end
      n_chk++;
      if (lat < LAT_MIN || lat > LAT_MAX) begin
         n_fail++; $display("FAIL add_latency: got %0d cycles want %0d..%0d", lat, LAT_MIN, LAT_MAX);
      end
   endtask

   task automatic test_alu_logic();
      logic [7:0] ops [5] = '{8'h22, 8'h24, 8'h27, 8'h25, 8'h26};
      logic [7:0] exp [5] = '{8'h02, 8'h01, 8'hF8, 8'h07, 8'h06};
      logic [9:0] fr;
      int         lat;
      write_reg(8'h00, 8'h05);
      write_reg(8'h01, 8'h03);
      for (int i = 0; i < 5; i++) begin
         write_reg(8'h02, ops[i]);
         read_result(fr, lat);
         n_chk++;
         if (fr !== {1'b1, exp[i], 1'b0}) begin
            n_fail++; $display("FAIL alu_op%02h: got %b want %b", ops[i], fr, {1'b1, exp[i], 1'b0});
         end
         n_chk++;
         if (lat < LAT_MIN || lat > LAT_MAX) begin
            n_fail++; $display("FAIL latency_op%02h: got %0d want %0d..%0d", ops[i], lat, LAT_MIN, LAT_MAX);
         end
      end
   endtask

   task automatic test_wrap();
      logic [9:0] fr;
      int         lat;
      write_reg(8'h00, 8'hF0);
      write_reg(8'h01, 8'h20);
      write_reg(8'h02, 8'h20);
      read_result(fr, lat);
      n_chk++;
      if (fr !== {1'b1, 8'h10, 1'b0}) begin n_fail++; $display("FAIL add_carry_drop: got %b want %b", fr, {1'b1, 8'h10, 1'b0}); end
      write_reg(8'h00, 8'h03);
      write_reg(8'h01, 8'h05);
      write_reg(8'h02, 8'h22);
      read_result(fr, lat);
      n_chk++;
      if (fr !== {1'b1, 8'hFE, 1'b0}) begin n_fail++; $display("FAIL sub_borrow_drop: got %b want %b", fr, {1'b1, 8'hFE, 1'b0}); end
   endtask

   task automatic test_shift();
      logic [7:0] ops [3] = '{8'h03, 8'h02, 8'h3F};
      logic [7:0] exp [3] = '{8'hE0, 8'h20, 8'h00};
      logic [9:0] fr;
      int         lat;
      write_reg(8'h00, 8'h80);
      write_reg(8'h01, 8'h02);
      for (int i = 0; i < 3; i++) begin
         write_reg(8'h02, ops[i]);
         read_result(fr, lat);
         n_chk++;
         if (fr !== {1'b1, exp[i], 1'b0}) begin
            n_fail++; $display("FAIL shift_op%02h: got %b want %b", ops[i], fr, {1'b1, exp[i], 1'b0});
         end
      end
   endtask

   task automatic test_bad_loc();
      logic [9:0] fr;
      int         lat;
      write_reg(8'h02, 8'h02);
      write_reg(8'h07, 8'h55);
      read_result(fr, lat);
      n_chk++;
      if (fr !== {1'b1, 8'h20, 1'b0}) begin n_fail++; $display("FAIL bad_location: got %b want %b", fr, {1'b1, 8'h20, 1'b0}); end
   endtask

   task automatic test_ff_data();
      logic [9:0] fr;
      int         lat;
      write_reg(8'h00, 8'hFF);
      read_result(fr, lat);
      n_chk++;
      if (fr !== {1'b1, 8'h3F, 1'b0}) begin n_fail++; $display("FAIL ff_as_value: got %b want %b", fr, {1'b1, 8'h3F, 1'b0}); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] seq [6] = '{8'h00, 8'h12, 8'h01, 8'h34, 8'h02, 8'h20};
      logic [9:0] fr;
      int         lat;
      for (int i = 0; i < 6; i++) send_byte(seq[i], 0);
      read_result(fr, lat);
      n_chk++;
      if (fr !== {1'b1, 8'h46, 1'b0}) begin n_fail++; $display("FAIL back_to_back: got %b want %b", fr, {1'b1, 8'h46, 1'b0}); end
   endtask

   task automatic test_reset_mid_tx();
      logic [9:0] fr;
      int         lat;
      int         w;
      int         lows;
      write_reg(8'h00, 8'h80);
      write_reg(8'h01, 8'h00);
      write_reg(8'h02, 8'h20);
      fork
         send_byte(8'hFF, GAP);
         begin
            w = 0;
            while (tx === 1'b1 && w < 20 * BIT) begin
               @(negedge clk);
               w++;
            end
            n_chk++;
            if (tx !== 1'b0) begin n_fail++; $display("FAIL midtx_frame_start: got %b want 0", tx); end
            repeat (100) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            n_chk++;
            if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_mid_tx: got %b want 1", tx); end
            rst = 1'b0;
            lows = 0;
            repeat (10 * BIT) begin
               @(negedge clk);
               if (tx !== 1'b1) lows++;
            end
            n_chk++;
            if (lows !== 0) begin n_fail++; $display("FAIL frame_aborted: %0d low cycles, want 0", lows); end
         end
      join
      read_result(fr, lat);
      n_chk++;
      if (fr !== {1'b1, 8'h00, 1'b0}) begin n_fail++; $display("FAIL post_reset_result: got %b want %b", fr, {1'b1, 8'h00, 1'b0}); end
   endtask

   task automatic test_glitch();
      logic [9:0] fr;
      int         lat;
      int         lows = 0;
      @(negedge clk);
      rx = 1'b0;
      repeat (4 * CLKS_PER_TICK) @(negedge clk);
      rx = 1'b1;
      repeat (3 * BIT) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      n_chk++;
      if (lows !== 0) begin n_fail++; $display("FAIL glitch_quiet: %0d low cycles, want 0", lows); end
      read_result(fr, lat);
      n_chk++;
      if (fr !== {1'b1, 8'h00, 1'b0}) begin n_fail++; $display("FAIL glitch_no_byte: got %b want %b", fr, {1'b1, 8'h00, 1'b0}); end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_add();
      test_alu_logic();
      test_wrap();
      test_shift();
      test_bad_loc();
      test_ff_data();
      test_back_to_back();
      test_reset_mid_tx();
      test_glitch();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      repeat (150000) @(posedge clk);
      $display("FAIL watchdog: simulation exceeded 150000 cycles");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
